// File: rtl/cart_bus_responder_if.sv
// Cartridge bus pins plus backing-memory request port seen by cart_bus_responder.
// slave = responder side, master = external bus master and memory backend.
interface cart_bus_responder_if;
    logic [15:0] bus_a;
    logic [7:0]  bus_d_in;
    logic        bus_nrd;
    logic        bus_nwr;
    logic        bus_ncs;
    logic [7:0]  bus_d_out;
    logic        bus_d_oe;
    logic [21:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    modport slave (
        input  bus_a, bus_d_in, bus_nrd, bus_nwr, bus_ncs, mem_rdata, mem_ack,
        output bus_d_out, bus_d_oe, mem_addr, mem_rd, mem_wr, mem_wdata
    );

    modport master (
        output bus_a, bus_d_in, bus_nrd, bus_nwr, bus_ncs, mem_rdata, mem_ack,
        input  bus_d_out, bus_d_oe, mem_addr, mem_rd, mem_wr, mem_wdata
    );
endinterface

// File: rtl/cart_bus_responder.sv
// Cartridge-side DMG bus target: synchronizes the async bus, decodes ROM/RAM/MBC1 bank
// register, and turns bus reads/writes into single-outstanding backing-memory requests.
module cart_bus_responder #(
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned BANK_BITS  = 5,
    parameter logic [3:0]  RAM_EN_KEY = 4'hA
) (
    input logic                 clk_8m,
    input logic                 rst_n,
    cart_bus_responder_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, SETTLE, RD_REQ, RD_WAIT, RD_HOLD, WR_WAIT, WR_DEC, WR_ACK, DONE
    } state_t;

    localparam logic [2:0] CNT_LAST = 3'(SETTLE_CYC - 1);

    state_t state, state_next;

    logic [15:0] a_m, a_s;
    logic [7:0]  d_m, d_s;
    logic        nrd_m, nrd_s, nwr_m, nwr_s, ncs_m, ncs_s;

    logic [2:0]           cnt;
    logic [15:0]          settle_addr;
    logic [15:0]          wr_addr;
    logic [7:0]           wr_data;
    logic                 wr_ncs;
    logic [BANK_BITS-1:0] rom_bank;
    logic                 ram_en;
    logic                 busy;
    logic [7:0]           d_out_q;
    logic [21:0]          mem_addr_q;
    logic [7:0]           mem_wdata_q;

    logic        rd_hit, wr_hit, addr_stable;
    logic [21:0] rd_addr;
    logic        mem_rd_c, mem_wr_c, oe_c;

    always_ff @(posedge clk_8m or negedge rst_n) begin
        if (!rst_n) begin
            a_m   <= '0;
            a_s   <= '0;
            d_m   <= '0;
            d_s   <= '0;
            nrd_m <= 1'b1;
            nrd_s <= 1'b1;
            nwr_m <= 1'b1;
            nwr_s <= 1'b1;
            ncs_m <= 1'b1;
            ncs_s <= 1'b1;
        end else begin
            a_m   <= bus.bus_a;
            a_s   <= a_m;
            d_m   <= bus.bus_d_in;
            d_s   <= d_m;
            nrd_m <= bus.bus_nrd;
            nrd_s <= nrd_m;
            nwr_m <= bus.bus_nwr;
            nwr_s <= nwr_m;
            ncs_m <= bus.bus_ncs;
            ncs_s <= ncs_m;
        end
    end

    assign addr_stable = (a_s == settle_addr);
    assign rd_hit = !settle_addr[15] || (settle_addr[15:13] == 3'b101 && !ncs_s && ram_en);
    assign wr_hit = (wr_addr[15:13] == 3'b101) && !wr_ncs && ram_en;

    always_comb begin
        if (!settle_addr[15])
            rd_addr = {(settle_addr[14] ? 8'(rom_bank) : 8'h00), settle_addr[13:0]};
        else
            rd_addr = {1'b1, 8'h00, settle_addr[12:0]};
    end

    always_ff @(posedge clk_8m or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            settle_addr <= '0;
            wr_addr     <= '0;
            wr_data     <= '0;
            wr_ncs      <= 1'b1;
            rom_bank    <= BANK_BITS'(1);
            ram_en      <= 1'b0;
            busy        <= 1'b0;
            d_out_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state <= state_next;

            if (state_next == SETTLE && state != SETTLE) begin
                settle_addr <= a_s;
                cnt         <= '0;
            end else if (state == SETTLE) begin
                if (!addr_stable) begin
                    settle_addr <= a_s;
                    cnt         <= '0;
                end else if (cnt != CNT_LAST) begin
                    cnt <= cnt + 3'd1;
                end
            end

            if (state_next == RD_REQ)
                mem_addr_q <= rd_addr;
            if (state == RD_WAIT && state_next == RD_HOLD)
                d_out_q <= bus.mem_rdata;

            // Keep the last address/data seen while the strobe was low; the bus may move after nWR rises.
            if (state_next == WR_WAIT && !nwr_s) begin
                wr_addr <= a_s;
                wr_data <= d_s;
                wr_ncs  <= ncs_s;
            end

            if (state == WR_WAIT && state_next == WR_DEC && wr_addr[15:13] == 3'b101) begin
                mem_addr_q  <= {1'b1, 8'h00, wr_addr[12:0]};
                mem_wdata_q <= wr_data;
            end

            if (state == WR_DEC) begin
                if (wr_addr[15:13] == 3'b000)
                    ram_en <= (wr_data[3:0] == RAM_EN_KEY);
                else if (wr_addr[15:13] == 3'b001)
                    rom_bank <= (wr_data[BANK_BITS-1:0] == '0) ? BANK_BITS'(1) : wr_data[BANK_BITS-1:0];
            end

            if (mem_rd_c || mem_wr_c)
                busy <= 1'b1;
            else if (bus.mem_ack)
                busy <= 1'b0;
        end
    end

    // A dropped read may still be outstanding; new requests wait for its ack.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (!nrd_s && nwr_s)
                    state_next = SETTLE;
                else if (nrd_s && !nwr_s)
                    state_next = WR_WAIT;
            end
            SETTLE: begin
                if (nrd_s)
                    state_next = IDLE;
                else if (addr_stable && cnt == CNT_LAST) begin
                    if (!rd_hit)
                        state_next = DONE;
                    else if (!busy)
                        state_next = RD_REQ;
                end
            end
            RD_REQ:  state_next = RD_WAIT;
            RD_WAIT: begin
                if (nrd_s)
                    state_next = IDLE;
                else if (bus.mem_ack)
                    state_next = RD_HOLD;
            end
            RD_HOLD: begin
                if (!nwr_s)
                    state_next = WR_WAIT;
                else if (nrd_s)
                    state_next = IDLE;
                else if (!addr_stable)
                    state_next = SETTLE;
            end
            WR_WAIT: if (nwr_s) state_next = WR_DEC;
            WR_DEC: begin
                if (!wr_hit)
                    state_next = IDLE;
                else if (!busy)
                    state_next = WR_ACK;
            end
            WR_ACK:  if (bus.mem_ack) state_next = IDLE;
            DONE:    if (nrd_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_rd_c = (state == RD_REQ);
        mem_wr_c = (state == WR_DEC) && wr_hit && !busy;
        oe_c     = rst_n && (state == RD_HOLD) && !nrd_s && nwr_s && addr_stable;
    end

    assign bus.bus_d_out = d_out_q;
    assign bus.bus_d_oe  = oe_c;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_rd    = mem_rd_c;
    assign bus.mem_wr    = mem_wr_c;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_cart_bus_responder.sv
// Bench for cart_bus_responder: vector table, hand-written corner sequences, and
// randomized bus traffic checked against a cartridge/MBC1 reference model.
`timescale 1ns/1ps
module tb_cart_bus_responder;
    logic clk;
    logic rst_n;
    cart_bus_responder_if bus();

    cart_bus_responder #(.SETTLE_CYC(2), .BANK_BITS(5), .RAM_EN_KEY(4'hA)) dut (
        .clk_8m(clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Backing memory model and request monitor
    int          rd_count = 0, wr_count = 0, ack_count = 0, both_seen = 0;
    logic [21:0] last_rd_addr = '0, last_wr_addr = '0;
    logic [7:0]  last_wdata = '0;
    int          ack_lat = 1;
    int          pending_lat = 0;
    logic [7:0]  pend_data = '0;
    logic        use_fixed = 1'b0;
    logic [7:0]  fixed_data = '0;

    // Cartridge reference state
    int model_bank = 1;
    bit model_ram_en = 0;

    function automatic logic [7:0] data_of(input logic [21:0] a);
        return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'h5A;
    endfunction

    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_ack = 1'b0;
            if (pending_lat > 0) begin
                pending_lat--;
                if (pending_lat == 0) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = pend_data;
                    ack_count++;
                end
            end
            if (bus.mem_rd && bus.mem_wr) both_seen++;
            if (bus.mem_rd) begin
                rd_count++;
                last_rd_addr = bus.mem_addr;
                pend_data    = use_fixed ? fixed_data : data_of(bus.mem_addr);
                pending_lat  = ack_lat;
            end else if (bus.mem_wr) begin
                wr_count++;
                last_wr_addr = bus.mem_addr;
                last_wdata   = bus.mem_wdata;
                pend_data    = '0;
                pending_lat  = ack_lat;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic model_write(input logic [15:0] a, input logic [7:0] d);
        if (a < 16'h2000) model_ram_en = (d % 16 == 10);
        else if (a < 16'h4000) model_bank = (d % 32 == 0) ? 1 : d % 32;
    endtask

    function automatic logic [21:0] model_rd_addr(input logic [15:0] a);
        if (a < 16'h8000) return 22'((a >= 16'h4000 ? model_bank * 16384 : 0) + a % 16384);
        return 22'(32'h200000 + a % 8192);
    endfunction

    function automatic bit model_rd_hit(input logic [15:0] a, input logic ncs);
        return (a < 16'h8000) || (a >= 16'hA000 && a < 16'hC000 && !ncs && model_ram_en);
    endfunction

    task automatic do_read(input string nm, input logic [15:0] a, input logic ncs,
                           input logic exp_hit, input logic [21:0] exp_addr, input logic [7:0] exp_data);
        int rd0;
        bit seen, dropped;
        rd0 = rd_count;
        seen = 0;
        dropped = 0;
        bus.bus_a = a;
        bus.bus_ncs = ncs;
        @(negedge clk);
        bus.bus_nrd = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (bus.bus_d_oe === 1'b1) seen = 1;
        end
        chk({nm, " oe"}, 32'(seen), 32'(exp_hit));
        if (exp_hit) begin
            chk({nm, " rd_cnt"}, rd_count - rd0, 1);
            chk({nm, " addr"}, 32'(last_rd_addr), 32'(exp_addr));
            repeat (2) @(negedge clk);
            chk({nm, " hold oe"}, 32'(bus.bus_d_oe), 1);
            chk({nm, " data"}, 32'(bus.bus_d_out), 32'(exp_data));
        end else begin
            chk({nm, " no rd"}, rd_count - rd0, 0);
        end
        bus.bus_nrd = 1'b1;
        for (int i = 0; i < 3 && !dropped; i++) begin
            @(negedge clk);
            if (bus.bus_d_oe === 1'b0) dropped = 1;
        end
        chk({nm, " oe drop"}, 32'(dropped), 1);
        repeat (3) @(negedge clk);
        bus.bus_ncs = 1'b1;
    endtask

    task automatic do_write(input string nm, input logic [15:0] a, input logic [7:0] d, input logic ncs,
                            input logic exp_wr, input logic [21:0] exp_addr);
        int wr0;
        wr0 = wr_count;
        bus.bus_a = a;
        bus.bus_d_in = d;
        bus.bus_ncs = ncs;
        @(negedge clk);
        bus.bus_nwr = 1'b0;
        repeat (4) @(negedge clk);
        bus.bus_nwr = 1'b1;
        repeat (7) @(negedge clk);
        bus.bus_ncs = 1'b1;
        chk({nm, " wr_cnt"}, wr_count - wr0, 32'(exp_wr));
        if (exp_wr) begin
            chk({nm, " waddr"}, 32'(last_wr_addr), 32'(exp_addr));
            chk({nm, " wdata"}, 32'(last_wdata), 32'(d));
        end
        model_write(a, d);
    endtask

    typedef struct {
        bit          wr;
        logic [15:0] a;
        logic [7:0]  d;
        logic        ncs;
        logic        exp_req;
        logic [21:0] exp_addr;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int rd0, wr0;
        bit seen, bad;
        logic [15:0] a;
        logic [7:0]  d;
        logic        ncs;

        vecs.push_back('{0, 16'h0150, 8'h3C, 1, 1, 22'h000150});
        vecs.push_back('{1, 16'h2000, 8'h00, 1, 0, 22'h0});
        vecs.push_back('{0, 16'h4123, 8'hA5, 1, 1, 22'h004123});
        vecs.push_back('{1, 16'h2000, 8'h05, 1, 0, 22'h0});
        vecs.push_back('{0, 16'h4123, 8'h5A, 1, 1, 22'h014123});
        vecs.push_back('{0, 16'h0123, 8'h11, 1, 1, 22'h000123});
        vecs.push_back('{0, 16'hA010, 8'h00, 0, 0, 22'h0});
        vecs.push_back('{1, 16'hA010, 8'h77, 0, 0, 22'h0});
        vecs.push_back('{1, 16'h0000, 8'h0A, 1, 0, 22'h0});
        vecs.push_back('{1, 16'hA010, 8'h77, 0, 1, 22'h200010});
        vecs.push_back('{0, 16'hA010, 8'h77, 0, 1, 22'h200010});
        vecs.push_back('{0, 16'hA010, 8'h00, 1, 0, 22'h0});
        vecs.push_back('{0, 16'hC000, 8'h00, 0, 0, 22'h0});
        vecs.push_back('{1, 16'h0000, 8'h00, 1, 0, 22'h0});
        vecs.push_back('{0, 16'hA010, 8'h00, 0, 0, 22'h0});
        vecs.push_back('{1, 16'h2000, 8'h1F, 1, 0, 22'h0});
        vecs.push_back('{0, 16'h7FFF, 8'h33, 1, 1, 22'h07FFFF});
        vecs.push_back('{1, 16'h2000, 8'hE0, 1, 0, 22'h0});
        vecs.push_back('{0, 16'h4000, 8'h44, 1, 1, 22'h004000});
        vecs.push_back('{1, 16'h4000, 8'h03, 1, 0, 22'h0});
        vecs.push_back('{0, 16'h4000, 8'h45, 1, 1, 22'h004000});

        bus.bus_a = '0;
        bus.bus_d_in = '0;
        bus.bus_nrd = 1'b1;
        bus.bus_nwr = 1'b1;
        bus.bus_ncs = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset oe", 32'(bus.bus_d_oe), 0);
        chk("reset d_out", 32'(bus.bus_d_out), 0);
        chk("reset mem_addr", 32'(bus.mem_addr), 0);
        chk("reset mem_req", 32'({bus.mem_rd, bus.mem_wr}), 0);
        chk("reset wdata", 32'(bus.mem_wdata), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        use_fixed = 1'b1;
        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                do_write($sformatf("vec%0d", i), vecs[i].a, vecs[i].d, vecs[i].ncs,
                         vecs[i].exp_req, vecs[i].exp_addr);
            end else begin
                fixed_data = vecs[i].d;
                do_read($sformatf("vec%0d", i), vecs[i].a, vecs[i].ncs,
                        vecs[i].exp_req, vecs[i].exp_addr, vecs[i].d);
            end
        end
        use_fixed = 1'b0;

        // Address moves 0x0100 -> 0x0200 while settling
        rd0 = rd_count;
        seen = 0;
        bus.bus_a = 16'h0100;
        @(negedge clk);
        bus.bus_nrd = 1'b0;
        repeat (2) @(negedge clk);
        bus.bus_a = 16'h0200;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (bus.bus_d_oe === 1'b1) seen = 1;
        end
        chk("settle oe", 32'(seen), 1);
        chk("settle rd_cnt", rd_count - rd0, 1);
        chk("settle addr", 32'(last_rd_addr), 32'h000200);
        chk("settle data", 32'(bus.bus_d_out), 32'(data_of(22'h000200)));
        bus.bus_nrd = 1'b1;
        repeat (6) @(negedge clk);

        // nRD and nWR low together: ignored
        rd0 = rd_count;
        wr0 = wr_count;
        bad = 0;
        bus.bus_a = 16'h0150;
        @(negedge clk);
        bus.bus_nrd = 1'b0;
        bus.bus_nwr = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.bus_d_oe !== 1'b0) bad = 1;
        end
        bus.bus_nrd = 1'b1;
        bus.bus_nwr = 1'b1;
        repeat (6) @(negedge clk);
        chk("both low oe", 32'(bad), 0);
        chk("both low req", (rd_count - rd0) + (wr_count - wr0), 0);

        // nRD released before a slow ack: late ack must not drive the bus
        ack_lat = 15;
        rd0 = rd_count;
        bad = 0;
        bus.bus_a = 16'h0300;
        @(negedge clk);
        bus.bus_nrd = 1'b0;
        for (int i = 0; i < 20 && rd_count == rd0; i++) @(negedge clk);
        chk("late rd_cnt", rd_count - rd0, 1);
        bus.bus_nrd = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.bus_d_oe !== 1'b0) bad = 1;
        end
        chk("late ack oe", 32'(bad), 0);
        chk("late ack seen", 32'(pending_lat), 0);
        ack_lat = 1;
        do_read("after late", 16'h0301, 1'b1, 1'b1, 22'h000301, data_of(22'h000301));

        // Randomized traffic against the cartridge model
        for (int k = 0; k < 60; k++) begin
            ack_lat = $urandom_range(1, 3);
            d = 8'($urandom);
            ncs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: begin
                    a = 16'($urandom_range(0, 16'h1FFF));
                    if ($urandom_range(0, 1)) d = {d[7:4], 4'hA};
                    do_write($sformatf("rnd%0d ramen", k), a, d, 1'b1, 1'b0, '0);
                end
                1: begin
                    a = 16'($urandom_range(16'h2000, 16'h3FFF));
                    do_write($sformatf("rnd%0d bank", k), a, d, 1'b1, 1'b0, '0);
                end
                2: begin
                    a = 16'($urandom_range(0, 16'h7FFF));
                    do_read($sformatf("rnd%0d rom", k), a, 1'b1, 1'b1, model_rd_addr(a), data_of(model_rd_addr(a)));
                end
                3: begin
                    a = 16'($urandom_range(16'hA000, 16'hBFFF));
                    do_read($sformatf("rnd%0d ramrd", k), a, ncs, model_rd_hit(a, ncs),
                            model_rd_addr(a), data_of(model_rd_addr(a)));
                end
                4: begin
                    a = 16'($urandom_range(16'hA000, 16'hBFFF));
                    do_write($sformatf("rnd%0d ramwr", k), a, d, ncs, model_rd_hit(a, ncs), model_rd_addr(a));
                end
                default: begin
                    a = 16'($urandom_range(16'hC000, 16'hFFFF));
                    do_read($sformatf("rnd%0d hi", k), a, ncs, 1'b0, '0, '0);
                end
            endcase
        end
        ack_lat = 1;

        // Reset while the bus is being driven
        do_write("pre rst bank", 16'h2000, 8'h05, 1'b1, 1'b0, '0);
        do_write("pre rst ramen", 16'h0000, 8'h0A, 1'b1, 1'b0, '0);
        seen = 0;
        bus.bus_a = 16'h0150;
        @(negedge clk);
        bus.bus_nrd = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (bus.bus_d_oe === 1'b1) seen = 1;
        end
        chk("pre rst oe", 32'(seen), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async rst oe", 32'(bus.bus_d_oe), 0);
        chk("async rst d_out", 32'(bus.bus_d_out), 0);
        chk("async rst mem_addr", 32'(bus.mem_addr), 0);
        bus.bus_nrd = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_bank = 1;
        model_ram_en = 0;
        repeat (3) @(negedge clk);
        do_read("post rst bank", 16'h4123, 1'b1, 1'b1, 22'h004123, data_of(22'h004123));
        do_read("post rst ramen", 16'hA010, 1'b0, 1'b0, '0, '0);

        chk("rd_wr exclusive", both_seen, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
